// File: rtl/button_debounce_fsm.sv
// button_debounce_fsm
// Cleans up a bouncy push-button level. The raw input is synchronised by two
// flops, then a four-state FSM requires the new level to hold for DEBOUNCE_N
// consecutive samples before the clean level A follows it. The rise and fall
// pulses mark the cycle in which A changes, for the downstream edge-detecting
// Mealy FSM.

module button_debounce_fsm #(
    parameter int DEBOUNCE_N = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic A,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        IDLE_LOW    = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } state_t;

    // Terminal count: the sample that leaves the stable state counts as
    // sample one, so the last wait cycle is reached at DEBOUNCE_N-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic             s;
    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;
    logic             next_a;
    logic             next_rise;
    logic             next_fall;

    assign s = sync2;

    // Two-flop synchroniser bringing the asynchronous button into the clk domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // State, stability counter and the registered Moore/pulse outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            A     <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            A     <= next_a;
            rise  <= next_rise;
            fall  <= next_fall;
        end
    end

    // Next-state logic: any disagreement with the accepted level must persist or it is thrown away
    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE_LOW: begin
                if (s) begin
                    next_state = WAIT_HIGH;
                    next_cnt   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (s) begin
                    if (cnt == CNT_LAST) begin
                        next_state = STABLE_HIGH;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CNT_ONE;
                    end
                end else begin
                    next_state = IDLE_LOW;
                    next_cnt   = '0;
                end
            end
            STABLE_HIGH: begin
                if (!s) begin
                    next_state = WAIT_LOW;
                    next_cnt   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (!s) begin
                    if (cnt == CNT_LAST) begin
                        next_state = IDLE_LOW;
                        next_cnt   = '0;
                    end else begin
                        next_cnt = cnt + CNT_ONE;
                    end
                end else begin
                    next_state = STABLE_HIGH;
                    next_cnt   = '0;
                end
            end
            default: begin
                next_state = IDLE_LOW;
                next_cnt   = '0;
            end
        endcase
    end

    // Output logic: A follows the state it lands in, pulses mark only the completed acceptances
    always_comb begin
        next_a    = 1'b0;
        next_rise = 1'b0;
        next_fall = 1'b0;
        next_a    = (next_state == STABLE_HIGH) || (next_state == WAIT_LOW);
        next_rise = (state == WAIT_HIGH) && (next_state == STABLE_HIGH);
        next_fall = (state == WAIT_LOW) && (next_state == IDLE_LOW);
    end

endmodule

// File: tb/tb_button_debounce_fsm.sv
// tb_button_debounce_fsm
// Drives button_debounce_fsm with DEBOUNCE_N=4. Directed vectors come from a
// hand-derived table; the long random run takes its expectations from a small
// run-length model of the debouncer. Every expectation goes into a queue when
// the stimulus is driven and is popped just after the clock edge that produces it.

module tb_button_debounce_fsm;

    localparam int N = 4;

    typedef struct {
        logic  rst;
        logic  btn;
        logic  ea;
        logic  er;
        logic  ef;
        string name;
    } vec_t;

    typedef struct {
        logic [2:0] exp;
        string      name;
    } sb_t;

    logic clk;
    logic reset;
    logic btn_raw;
    logic A;
    logic rise;
    logic fall;

    int   total;
    int   bad;
    vec_t vecs[$];
    sb_t  sbq[$];

    // Reference model state: synchroniser copies, accepted level, run length of disagreement
    logic mSync1;
    logic mSync2;
    logic mA;
    int   mRun;

    button_debounce_fsm #(
        .DEBOUNCE_N(N),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_raw(btn_raw),
        .A(A),
        .rise(rise),
        .fall(fall)
    );

    // Free-running 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic addVec(input logic rst, input logic btn, input logic ea,
                          input logic er, input logic ef, input string name);
        vec_t v;
        v.rst  = rst;
        v.btn  = btn;
        v.ea   = ea;
        v.er   = er;
        v.ef   = ef;
        v.name = name;
        vecs.push_back(v);
    endtask

    // Drive one cycle of inputs away from the edge and queue what the edge must produce
    task automatic applyStimulus(input logic rst, input logic btn,
                                 input logic [2:0] exp, input string name);
        sb_t e;
        @(negedge clk);
        reset   = rst;
        btn_raw = btn;
        e.exp   = exp;
        e.name  = name;
        sbq.push_back(e);
    endtask

    // Wait for the edge, then pop the oldest expectation and compare
    task automatic checkOutput();
        sb_t e;
        @(posedge clk);
        #1;
        total++;
        if (sbq.size() == 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_empty: got A/rise/fall=%b%b%b, no expectation queued",
                     A, rise, fall);
        end else begin
            e = sbq.pop_front();
            if ({A, rise, fall} !== e.exp) begin
                bad++;
                $display("[TB] FAIL %s: got A/rise/fall=%b%b%b, required %b at time %0t",
                         e.name, A, rise, fall, e.exp, $time);
            end
        end
    endtask

    // One clock of the reference model: a flip happens after N straight disagreeing samples
    task automatic modelStep(input logic rst, input logic btn, output logic [2:0] e);
        logic s;
        s = mSync2;
        if (rst) begin
            mSync1 = 1'b0;
            mSync2 = 1'b0;
            mA     = 1'b0;
            mRun   = 0;
            e      = 3'b000;
        end else begin
            mSync2 = mSync1;
            mSync1 = btn;
            if (s != mA) begin
                mRun++;
                if (mRun == N) begin
                    mA   = ~mA;
                    mRun = 0;
                    e    = {mA, mA, ~mA};
                end else begin
                    e = {mA, 2'b00};
                end
            end else begin
                mRun = 0;
                e    = {mA, 2'b00};
            end
        end
    endtask

    task automatic runOne(input logic rst, input logic btn,
                          input logic [2:0] exp, input string name);
        applyStimulus(rst, btn, exp, name);
        checkOutput();
    endtask

    // Main test sequence
    initial begin
        logic [2:0] e;
        logic       btn;
        logic       prevA;
        logic       wantRise;

        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        btn_raw = 1'b0;
        mSync1  = 1'b0;
        mSync2  = 1'b0;
        mA      = 1'b0;
        mRun    = 0;

        // Reset held two cycles
        for (int i = 0; i < 2; i++) addVec(1, 0, 0, 0, 0, "reset_state");
        // Button held high: accepted after edge 5
        for (int i = 0; i < 5; i++) addVec(0, 1, 0, 0, 0, "hold_hi_waiting");
        addVec(0, 1, 1, 1, 0, "rise_at_edge5");
        for (int i = 0; i < 2; i++) addVec(0, 1, 1, 0, 0, "hold_hi_stable");
        // Button held low: released after edge 5
        for (int i = 0; i < 5; i++) addVec(0, 0, 1, 0, 0, "hold_lo_waiting");
        addVec(0, 0, 0, 0, 1, "fall_at_edge5");
        for (int i = 0; i < 2; i++) addVec(0, 0, 0, 0, 0, "hold_lo_stable");
        // Three-cycle pulse is rejected
        for (int i = 0; i < 10; i++) addVec(0, (i < 3), 0, 0, 0, "pulse3_rejected");
        // Four-cycle pulse is accepted once and then released
        for (int i = 0; i < 5; i++) addVec(0, (i < 4), 0, 0, 0, "pulse4_waiting");
        addVec(0, 0, 1, 1, 0, "pulse4_rise");
        for (int i = 0; i < 3; i++) addVec(0, 0, 1, 0, 0, "pulse4_high");
        addVec(0, 0, 0, 0, 1, "pulse4_fall");
        for (int i = 0; i < 2; i++) addVec(0, 0, 0, 0, 0, "pulse4_low");

        for (int i = 0; i < vecs.size(); i++) begin
            runOne(vecs[i].rst, vecs[i].btn, {vecs[i].ea, vecs[i].er, vecs[i].ef}, vecs[i].name);
        end

        // Bounce while high: get to stable high first
        for (int i = 0; i < 5; i++) runOne(0, 1, 3'b000, "bounce_setup_wait");
        runOne(0, 1, 3'b110, "bounce_setup_rise");
        for (int i = 0; i < 2; i++) runOne(0, 1, 3'b100, "bounce_setup_high");
        // Raw 1,0,1,0,1 then settles low: single fall after four straight lows of s
        for (int k = 0; k < 12; k++) begin
            btn = (k < 5) ? ((k % 2) == 0) : 1'b0;
            if (k < 10)       runOne(0, btn, 3'b100, "bounce_hold_high");
            else if (k == 10) runOne(0, btn, 3'b001, "bounce_single_fall");
            else              runOne(0, btn, 3'b000, "bounce_after_fall");
        end

        // Reset in WAIT_HIGH with cnt=2 (after two counting edges), button still high
        for (int i = 0; i < 4; i++) runOne(0, 1, 3'b000, "midwait_approach");
        runOne(1, 1, 3'b000, "midwait_reset");
        for (int i = 0; i < 5; i++) runOne(0, 1, 3'b000, "midwait_redebounce");
        runOne(0, 1, 3'b110, "midwait_rise_again");
        runOne(0, 1, 3'b100, "midwait_stable");

        // Reset while high must not produce a fall pulse afterwards
        runOne(1, 0, 3'b000, "reset_from_high");
        for (int i = 0; i < 6; i++) runOne(0, 0, 3'b000, "no_pulse_after_reset");

        // Random bouncy input checked against the model plus pulse/level consistency
        for (int i = 0; i < 2; i++) begin
            modelStep(1, 0, e);
            runOne(1, 0, e, "random_reset");
        end
        btn      = 1'b0;
        prevA    = 1'b0;
        wantRise = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 5) == 0) btn = ~btn;
            modelStep(0, btn, e);
            runOne(0, btn, e, "random_model");

            total++;
            if (rise && fall) begin
                bad++;
                $display("[TB] FAIL pulses_coincide: got rise=%b fall=%b, required not both 1", rise, fall);
            end
            total++;
            if ((rise !== (A & ~prevA)) || (fall !== (~A & prevA))) begin
                bad++;
                $display("[TB] FAIL pulse_vs_level: got A=%b prevA=%b rise=%b fall=%b, required pulses on A change only",
                         A, prevA, rise, fall);
            end
            if (rise || fall) begin
                total++;
                if (rise !== wantRise) begin
                    bad++;
                    $display("[TB] FAIL pulse_order: got rise=%b fall=%b, required rise=%b", rise, fall, wantRise);
                end
                wantRise = ~rise;
            end
            prevA = A;
        end

        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("[TB] FAIL scoreboard_leftover: got %0d entries, required 0", sbq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
